// File: rtl/mem_access_ctrl.sv
// Load/store access controller: turns CPU byte/half/word requests into aligned
// 32-bit word reads and writes, with read-modify-write for sub-word stores.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        store,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic        store_q, store_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;

  logic        misaligned;
  logic [31:0] merged;

  // Lane-select a load result out of a full memory word and extend it.
  function automatic logic [31:0] extract(input logic [31:0] w,
                                          input logic [1:0]  sz,
                                          input logic [1:0]  lane,
                                          input logic        sx);
    logic [7:0]  b;
    logic [15:0] h;
    unique case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    unique case (sz)
      SZ_BYTE: extract = {{24{sx & b[7]}}, b};
      SZ_HALF: extract = {{16{sx & h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  always_comb begin
    misaligned = (size == 2'b11)
              || (size == SZ_HALF && addr[0])
              || (size == SZ_WORD && addr[1:0] != 2'b00);
  end

  // Store data merged into the word captured in RD.
  always_comb begin
    merged = word_q;
    unique case (size_q)
      SZ_BYTE: begin
        unique case (addr_q[1:0])
          2'd0:    merged[7:0]   = wdata_q[7:0];
          2'd1:    merged[15:8]  = wdata_q[7:0];
          2'd2:    merged[23:16] = wdata_q[7:0];
          default: merged[31:24] = wdata_q[7:0];
        endcase
      end
      SZ_HALF: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    sext_d  = sext_q;
    store_d = store_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;

    unique case (state_q)
      // The done cycle also accepts a request, giving back-to-back throughput.
      S_IDLE, S_DONE, S_ERR: begin
        state_d = S_IDLE;
        if (req) begin
          addr_d  = addr;
          size_d  = size;
          sext_d  = sext;
          store_d = store;
          wdata_d = wdata;
          if (misaligned)                   state_d = S_ERR;
          else if (store && size == SZ_WORD) state_d = S_WR;
          else                              state_d = S_RD;
        end
      end
      S_RD: begin
        word_d = mem_dout;
        if (store_q) begin
          state_d = S_WR;
        end else begin
          rdata_d = extract(mem_dout, size_q, addr_q[1:0], sext_q);
          state_d = S_DONE;
        end
      end
      S_WR:    state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      store_q <= 1'b0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      store_q <= store_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode from state only, so reset clears them asynchronously.
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE) || (state_q == S_ERR);
    err      = (state_q == S_ERR);
    mem_we   = (state_q == S_WR);
    mem_din  = mem_we ? merged : 32'h0;
    mem_addr = {addr_q[15:2], 2'b00};
    rdata    = rdata_q;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a byte-level reference memory predicts
// each response; a negedge monitor checks it whenever done is presented.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        store;
  logic [1:0]  size;
  logic        sext;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic        busy, done, err, mem_we;
  logic [31:0] rdata, mem_din, mem_dout;
  logic [15:0] mem_addr;

  mem_access_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .store    (store),
    .size     (size),
    .sext     (sext),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  always #5 clk = ~clk;

  // Data memory device: combinational read, word write on the clock edge.
  logic [31:0] dev_mem [0:16383];
  assign mem_dout = dev_mem[mem_addr[15:2]];
  always @(posedge clk) if (mem_we) dev_mem[mem_addr[15:2]] <= mem_din;

  // Reference model state.
  logic [7:0]  ref_mem [0:65535];
  logic [31:0] model_rdata = 32'h0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          we_n;
    logic [15:0] waddr;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   we_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
  endfunction

  // Byte-addressed little-endian model of one request.
  function automatic void model(input logic st, input logic [1:0] sz, input logic sx,
                                input logic [15:0] a, input logic [31:0] wd,
                                output exp_t e);
    int nb;
    logic [31:0] v;
    e.err   = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    e.acc   = 0;
    e.lat   = e.err ? 0 : ((st && sz != 2'd2) ? 2 : 1);
    e.we_n  = (st && !e.err) ? 1 : 0;
    e.waddr = a & 16'hFFFC;
    if (!e.err) begin
      nb = 1 << sz;
      if (st) begin
        for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
        if (sx && nb < 4 && v[8*nb-1])
          for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
        model_rdata = v;
      end
    end
    e.rdata = model_rdata;
  endfunction

  // Monitor: pops the scoreboard on every done.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      we_cnt = 0;
    end else begin
      if (mem_we) begin
        we_cnt = we_cnt + 1;
        if (exp_q.size() > 0) check("mem_addr_on_write", 32'(mem_addr), 32'(exp_q[0].waddr));
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, expected no done (err=%0b)", err);
        end else begin
          mon_e = exp_q.pop_front();
          check("err", 32'(err), 32'(mon_e.err));
          check("rdata", rdata, mon_e.rdata);
          check("done_latency", 32'(cyc), 32'(mon_e.acc + mon_e.lat + 1));
          check("write_count", 32'(we_cnt), 32'(mon_e.we_n));
        end
        we_cnt = 0;
      end
    end
  end

  // Issue one request at a negedge; returns at the negedge of its done cycle.
  task automatic issue(input logic st, input logic [1:0] sz, input logic sx,
                       input logic [15:0] a, input logic [31:0] wd, input bit noise);
    exp_t e;
    int   n;
    model(st, sz, sx, a, wd, e);
    store = st; size = sz; sext = sx; addr = a; wdata = wd; req = 1'b1;
    @(posedge clk);
    e.acc = cyc;
    exp_q.push_back(e);
    n = 0;
    forever begin
      @(negedge clk);
      if (n == 0) check("busy_after_accept", 32'(busy), 32'h1);
      if (done) break;
      n++;
      if (n > 8) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
        break;
      end
      if (noise) begin
        req   = 1'b1;
        store = 1'($urandom_range(0, 1));
        size  = 2'($urandom_range(0, 3));
        sext  = 1'($urandom_range(0, 1));
        addr  = 16'($urandom_range(0, 63));
        wdata = $urandom;
      end else begin
        req = 1'b0;
      end
    end
    req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ra;
    logic [1:0]  rs;
    for (int i = 0; i < 16384; i++) dev_mem[i] = 32'h0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h0;
    rst = 1'b1; req = 1'b0; store = 1'b0; size = 2'b00; sext = 1'b0;
    addr = 16'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_mem_we", 32'(mem_we), 32'h0);
    check("reset_mem_addr", 32'(mem_addr), 32'h0);
    check("reset_mem_din", mem_din, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed sequence.
    issue(1'b1, 2'd2, 1'b0, 16'h0010, 32'h11223344, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, 1'b0);
    check("lw_0010", rdata, 32'h11223344);
    issue(1'b0, 2'd0, 1'b1, 16'h0013, 32'h0, 1'b0);
    check("lb_0013", rdata, 32'h00000011);
    issue(1'b0, 2'd1, 1'b0, 16'h0012, 32'h0, 1'b0);
    check("lhu_0012", rdata, 32'h00001122);
    issue(1'b0, 2'd0, 1'b0, 16'h0010, 32'h0, 1'b0);
    check("lbu_0010", rdata, 32'h00000044);
    issue(1'b1, 2'd0, 1'b0, 16'h0011, 32'h000000AB, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 16'h0011, 32'h0, 1'b0);
    check("lb_0011", rdata, 32'hFFFFFFAB);
    issue(1'b0, 2'd0, 1'b0, 16'h0011, 32'h0, 1'b0);
    check("lbu_0011", rdata, 32'h000000AB);
    issue(1'b1, 2'd1, 1'b0, 16'h0012, 32'h0000BEEF, 1'b0);
    issue(1'b0, 2'd1, 1'b1, 16'h0012, 32'h0, 1'b0);
    check("lh_0012", rdata, 32'hFFFFBEEF);
    issue(1'b0, 2'd1, 1'b0, 16'h0011, 32'h0, 1'b0);
    issue(1'b1, 2'd2, 1'b0, 16'h0012, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 2'd3, 1'b0, 16'h0010, 32'h0, 1'b0);
    check("rdata_after_errors", rdata, 32'hFFFFBEEF);
    issue(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, 1'b1);
    check("lw_after_rmw", rdata, 32'hBEEFAB44);
    check("mem_word_0010", dev_mem[4], 32'hBEEFAB44);

    // Reset in the WR cycle of a byte store aborts the write.
    @(negedge clk);
    store = 1'b1; size = 2'd0; sext = 1'b0; addr = 16'h0011; wdata = 32'h55; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #1 check("abort_we_in_wr", 32'(mem_we), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("abort_mem_we", 32'(mem_we), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_rdata", rdata, 32'h0);
    check("abort_mem_din", mem_din, 32'h0);
    check("abort_mem_addr", 32'(mem_addr), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_rdata = 32'h0;
    check("abort_mem_word", dev_mem[4], ref_word(4));
    issue(1'b0, 2'd0, 1'b0, 16'h0011, 32'h0, 1'b0);
    check("load_after_abort", rdata, 32'h000000AB);

    // Randomized traffic over a small window so stores and loads collide.
    for (int t = 0; t < 200; t++) begin
      ra = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
      rs = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) begin
        if (rs == 2'd1) ra[0] = 1'b0;
        if (rs == 2'd2) ra[1:0] = 2'b00;
      end
      issue(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom,
            $urandom_range(0, 3) == 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    for (int i = 0; i < 16384; i++)
      if (dev_mem[i] !== ref_word(i)) check("final_mem_word", dev_mem[i], ref_word(i));
    for (int i = 0; i < 32; i++) check("final_window_word", dev_mem[i], ref_word(i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
